// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU-op and datapath select values, and the per-state control word.
package control_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_HALT
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // ALUOp as consumed by the ALU control decoder
   localparam logic [1:0] ALUOP_FUNCT = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_ADD   = 2'd2;

   localparam logic [1:0] SRCA_PC     = 2'd0;
   localparam logic [1:0] SRCA_RS1    = 2'd1;
   localparam logic [1:0] SRCA_OLDPC  = 2'd2;
   localparam logic [1:0] SRCB_RS2    = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] PCSRC_ALU   = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT= 2'd1;
   localparam logic [1:0] WB_ALUOUT   = 2'd0;
   localparam logic [1:0] WB_MDR      = 2'd1;
   localparam logic [1:0] WB_PC       = 2'd2;

   // Registered control word. fetch_en / br_en are qualifiers that get
   // combined with mem_ready / branch condition outside the register.
   typedef struct packed {
      logic       fetch_en;
      logic       br_en;
      logic       pc_wr;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic [1:0] wb_sel;
      logic       halted;
   } ctrl_t;

   // Control word presented while sitting in state s
   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.fetch_en  = 1'b1;
            c.mem_read  = 1'b1;
            c.alu_src_a = SRCA_PC;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALUOP_ADD;
            c.pc_src    = PCSRC_ALU;
         end
         S_DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXEC_I: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            c.reg_write = 1'b1;
            c.wb_sel    = WB_ALUOUT;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: c.mem_read  = 1'b1;
         S_MEM_WR: c.mem_write = 1'b1;
         S_MEM_WB: begin
            c.reg_write = 1'b1;
            c.wb_sel    = WB_MDR;
         end
         S_BRANCH: begin
            c.br_en     = 1'b1;
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALUOP_SUB;
            c.pc_src    = PCSRC_ALUOUT;
         end
         S_JAL: begin
            c.reg_write = 1'b1;
            c.wb_sel    = WB_PC;
            c.pc_wr     = 1'b1;
            c.pc_src    = PCSRC_ALUOUT;
         end
         S_HALT:  c.halted = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running cycle and retired-instruction counters, wrapping at 2^W.
module perf_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cyc_inc,
   input  logic         ret_inc,
   output logic [W-1:0] cycle_cnt,
   output logic [W-1:0] instret_cnt
);

   // Both counters clear on reset and wrap naturally on overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (cyc_inc) cycle_cnt   <= cycle_cnt + 1'b1;
         if (ret_inc) instret_cnt <= instret_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM. Datapath controls are registered from the
// next state; the only input-dependent enables (ir_write/pc_write on fetch
// completion, pc_write on branch) are qualified by registered strobes, so
// reset zeroes every output without waiting for a clock edge.
// Optional: define MULTICYCLE_PERF_CNT_EN to add cycle_cnt / instret_cnt.
module multicycle_control #(
   parameter int PERF_W = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [6:0]        opcode,
   input  logic              funct3_0,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              pc_write,
   output logic              ir_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic              reg_write,
   output logic [1:0]        alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [1:0]        alu_op,
   output logic [1:0]        pc_src,
   output logic [1:0]        wb_sel,
   output logic              halted
`ifdef MULTICYCLE_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] cycle_cnt,
   output logic [PERF_W-1:0] instret_cnt
`endif
);
   import control_pkg::*;

   state_t st, ns;
   ctrl_t  ctrl;
   logic   fetch_done;

   // fetch_en is low for the single idle cycle after reset, so the first
   // real fetch starts on the first edge after RESET drops
   assign fetch_done = ctrl.fetch_en & mem_ready;

   // Next-state rules; mem_ready only matters in FETCH / MEM_RD / MEM_WR
   always_comb begin
      ns = st;
      case (st)
         S_FETCH:  if (fetch_done) ns = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:               ns = S_EXEC_R;
               OP_I:               ns = S_EXEC_I;
               OP_LOAD, OP_STORE:  ns = S_MEM_ADDR;
               OP_BRANCH:          ns = S_BRANCH;
               OP_JAL:             ns = S_JAL;
               default:            ns = S_HALT;
            endcase
         end
         S_EXEC_R, S_EXEC_I:                     ns = S_ALU_WB;
         S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL:    ns = S_FETCH;
         S_MEM_ADDR: ns = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) ns = S_MEM_WB;
         S_MEM_WR:   if (mem_ready) ns = S_FETCH;
         default:    ns = S_HALT;
      endcase
   end

   // State register plus control word for the state being entered
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         st   <= S_FETCH;
         ctrl <= '0;
      end else begin
         st   <= ns;
         ctrl <= decode_ctrl(ns);
      end
   end

   assign ir_write  = fetch_done;
   assign pc_write  = fetch_done | ctrl.pc_wr | (ctrl.br_en & (zero ^ funct3_0));
   assign mem_read  = ctrl.mem_read;
   assign mem_write = ctrl.mem_write;
   assign reg_write = ctrl.reg_write;
   assign alu_src_a = ctrl.alu_src_a;
   assign alu_src_b = ctrl.alu_src_b;
   assign alu_op    = ctrl.alu_op;
   assign pc_src    = ctrl.pc_src;
   assign wb_sel    = ctrl.wb_sel;
   assign halted    = ctrl.halted;

`ifdef MULTICYCLE_PERF_CNT_EN
   logic cyc_inc, ret_inc;

   assign cyc_inc = (st != S_HALT);
   assign ret_inc = (st != S_FETCH) && (ns == S_FETCH);

   perf_counter #(.W(PERF_W)) u_perf (
      .clk        (CLK),
      .rst        (RESET),
      .cyc_inc    (cyc_inc),
      .ret_inc    (ret_inc),
      .cycle_cnt  (cycle_cnt),
      .instret_cnt(instret_cnt)
   );
`endif

endmodule
